// File: rtl/byte_packer_pkg.sv
// ----------------------------------------------------------------------------
// byte_packer_pkg
// Shared definitions for the byte-to-word packer.
//   BYTE_W     : width of one lane on the byte side.
//   WORD_BYTES : default number of bytes packed into one output word.
//   keep_lane  : one bit of the top-aligned keep mask. Lane i of a word that
//                is `bytes` lanes wide is valid when it is one of the top `n`
//                lanes (byte 0 lives in the most significant lane).
// ----------------------------------------------------------------------------
package byte_packer_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    // Returns the mask bit for lane index i (0 = least significant lane)
    // when n bytes have been packed into a word of `bytes` lanes.
    function automatic logic keep_lane(input int unsigned bytes,
                                       input int unsigned n,
                                       input int unsigned i);
        return (i < bytes) && ((i + n) >= bytes);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
// Packs a stream of bytes into BYTES-wide words, first byte in the most
// significant lane. A word is emitted when all lanes are filled or when the
// byte carrying in_last arrives; unused low lanes are zero and masked off by
// out_keep.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_data   : incoming byte
//   in_valid  : in_data valid
//   in_last   : current byte ends the packet (qualified by in_valid)
//   in_ready  : byte accepted when in_valid && in_ready
//   out_data  : assembled word, byte k at [8*(BYTES-k)-1 -: 8]
//   out_keep  : lane mask, bit (BYTES-1-k) set for byte k
//   out_last  : word closes a packet
//   out_valid : out_data/out_keep/out_last valid
//   out_ready : word consumed when out_valid && out_ready
// ----------------------------------------------------------------------------
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int BYTES = WORD_BYTES   // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [BYTE_W*BYTES-1:0] out_data,
    output logic [BYTES-1:0]      out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = $clog2(BYTES);
    localparam int WORD_W = BYTE_W * BYTES;

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] asm_q;

    logic              accept;
    logic              complete;
    logic [WORD_W-1:0] merged;
    logic [BYTES-1:0]  keep_next;

    // Only a held, unconsumed word can block input; a word being drained this
    // cycle frees the output register for whatever completes on the same edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == CNT_W'(BYTES - 1)));

    // Lane write-enable decode: the incoming byte replaces lane cnt. Lanes
    // above cnt are still zero because the assembly register is cleared on
    // every completion, which gives the zero fill for short words for free.
    always_comb begin
        merged    = asm_q;
        keep_next = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[BYTE_W*(BYTES-k)-1 -: BYTE_W] = in_data;
            end
        end
        for (int i = 0; i < BYTES; i++) begin
            keep_next[i] = keep_lane(BYTES, int'(cnt) + 1, i);
        end
    end

    // Counter, assembly register and output registers. The drain clears
    // out_valid first; a completing accept on the same edge overrides it so
    // back-to-back words flow without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            asm_q     <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    out_data  <= merged;
                    out_keep  <= keep_next;
                    out_last  <= in_last;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    asm_q     <= '0;
                end else begin
                    asm_q <= merged;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
Serial-to-parallel word assembler. Accepts a stream of bytes over a valid/ready handshake and packs them into 32-bit words, first-arriving byte in the most significant lane: bits [31:24] first, then [23:16], [15:8] and [7:0]. This is the inverse of the word-to-byte splitter on the byte datapath. It feeds the word-side consumer, and partial words are flushed on an end-of-packet marker.

Parameters:
BYTES, 4, bytes per output word (must be >= 2); word width is 8*BYTES.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  8  incoming byte.
in_valid  input  1  in_data valid.
in_last  input  1  qualifies with in_valid; the current byte ends the packet.
in_ready  output  1  byte accepted when in_valid && in_ready.
out_data  output  8*BYTES  assembled word, byte k of the word at [8*(BYTES-k)-1 -: 8].
out_keep  output  BYTES  lane valid mask, bit (BYTES-1-k) set for byte k.
out_last  output  1  word closes a packet.
out_valid  output  1  out_data/out_keep/out_last valid.
out_ready  input  1  word consumed when out_valid && out_ready.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, byte counter cnt=0, assembly register=0. in_ready is combinational and reads 1 after reset.
- in_ready = !out_valid || out_ready. It has no combinational dependence on in_valid or in_last.
- Accept: on accept with cnt<BYTES-1 and in_last=0, store the byte in assembly lane cnt and set cnt+=1. The output registers do not change.
- Completion: on accept with cnt==BYTES-1, or with in_last=1, load the output registers on the same edge:
  - out_data = assembly lanes 0..cnt-1, with the incoming byte in lane cnt.
  - Lanes above cnt are zero-filled.
  - out_keep has the top cnt+1 bits set and the rest 0.
  - out_last = in_last.
  - out_valid = 1.
  - cnt returns to 0 and the assembly register clears to 0.
- Latency: out_valid rises on the clock edge that accepts the completing byte, so the word is visible the next cycle.
- Output hold: while out_valid && !out_ready, out_data, out_keep and out_last stay stable and in_ready=0. No byte is accepted, including non-completing bytes.
- Simultaneous drain/fill: with out_valid=1, out_ready=1 and a completing accept on the same edge, the new word replaces the old one and out_valid stays 1. With no completing accept, out_valid falls to 0.
- Throughput: with out_ready tied high, one byte per cycle and one full word every BYTES cycles with no bubbles.
- in_last on the final lane (cnt==BYTES-1): full word, out_keep all ones, out_last=1.
- in_valid=0: no state change. in_data and in_last are ignored.
- Reset mid-word: the partial word is discarded, a pending output word is dropped (out_valid=0), and cnt=0.
- The counter width is clog2(BYTES). cnt never exceeds BYTES-1.

Decomposition:
- Shared package: BYTE_W=8, default WORD_BYTES=4, and the keep-mask helper function (count to top-aligned mask).
- Single module. The counter and the lane write-enable decode stay inline; no sub-module is natural.

Test Plan:
- Reset, then bytes 11,22,33,44 back-to-back with out_ready=1 -> one word 32'h11223344, keep 4'b1111, last=0, out_valid high for exactly 1 cycle, 4 cycles after the first accept.
- Bytes AA,BB with in_last on BB -> 32'hAABB0000, keep 4'b1100, last=1. The next bytes 01,02,03,04 give 32'h01020304 (counter and lanes cleared).
- Backpressure: complete word DEADBEEF with out_ready=0 for 5 cycles, in_valid held high with next byte 55 -> in_ready=0 and output stable throughout; 55 accepted only on the cycle out_ready=1; the next word starts with lane 0 = 55.
- Single byte 7E with in_last -> 32'h7E000000, keep 4'b1000, last=1.
- Assert rst_n=0 asynchronously after 2 bytes of a word and with an unconsumed word pending -> out_valid=0 immediately. After release, bytes 10,20,30,40 -> 32'h10203040.
- Continuous stream of 16 bytes 00..0F with out_ready=1 -> 4 words 00010203, 04050607, 08090A0B, 0C0D0E0F, no in_ready deassertion.
